// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester round-robin arbiter in front of a single memory
//               path. Each access takes IDLE -> ACCESS -> RESP, three cycles.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  input  logic [2:0]  a_ctrl,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  input  logic [2:0]  b_ctrl,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,
  output logic [31:0] m_addr,
  output logic [31:0] m_dataW,
  output logic [2:0]  m_ctrl,
  output logic        m_memR,
  output logic        m_memW,
  input  logic [31:0] m_dataR,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_b_q, last_b_d;   // 1 when B held the most recent grant
  logic        win_b_q, win_b_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] rdata_q, rdata_d;
  logic        gnt_a, gnt_b;

  // Gated by rst_n so no grant can appear while reset is still asserted.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (rst_n && (state_q == IDLE)) begin
      if (a_req && (!b_req || last_b_q)) begin
        gnt_a = 1'b1;
      end else if (b_req) begin
        gnt_b = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    win_b_d  = win_b_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ctrl_d   = ctrl_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (gnt_a || gnt_b) begin
          state_d  = ACCESS;
          last_b_d = gnt_b;
          win_b_d  = gnt_b;
          we_d     = gnt_b ? b_we    : a_we;
          addr_d   = gnt_b ? b_addr  : a_addr;
          wdata_d  = gnt_b ? b_wdata : a_wdata;
          ctrl_d   = gnt_b ? b_ctrl  : a_ctrl;
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (!we_q) begin
          rdata_d = m_dataR;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_b_q <= 1'b1;
      win_b_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      ctrl_q   <= 3'd0;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      win_b_q  <= win_b_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ctrl_q   <= ctrl_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    a_gnt    = gnt_a;
    b_gnt    = gnt_b;
    a_rvalid = 1'b0;
    a_rdata  = 32'd0;
    b_rvalid = 1'b0;
    b_rdata  = 32'd0;
    m_addr   = 32'd0;
    m_dataW  = 32'd0;
    m_ctrl   = 3'd0;
    m_memR   = 1'b0;
    m_memW   = 1'b0;
    busy     = (state_q != IDLE);
    case (state_q)
      ACCESS: begin
        m_addr  = addr_q;
        m_dataW = wdata_q;
        m_ctrl  = ctrl_q;
        m_memR  = !we_q;
        m_memW  = we_q;
      end
      RESP: begin
        if (win_b_q) begin
          b_rvalid = 1'b1;
          b_rdata  = we_q ? 32'd0 : rdata_q;
        end else begin
          a_rvalid = 1'b1;
          a_rdata  = we_q ? 32'd0 : rdata_q;
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed vector bench for mem_arbiter.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata, m_dataR;
  logic [2:0]  a_ctrl, b_ctrl;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid, m_memR, m_memW, busy;
  logic [31:0] a_rdata, b_rdata, m_addr, m_dataW;
  logic [2:0]  m_ctrl;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ctrl(a_ctrl),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ctrl(b_ctrl),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .m_addr(m_addr), .m_dataW(m_dataW), .m_ctrl(m_ctrl),
    .m_memR(m_memR), .m_memW(m_memW), .m_dataR(m_dataR), .busy(busy)
  );

  typedef struct packed {
    logic        ar; logic aw; logic [31:0] aa; logic [31:0] ad; logic [2:0] ac;
    logic        br; logic bw; logic [31:0] ba; logic [31:0] bd; logic [2:0] bc;
    logic [31:0] dr;
  } in_t;

  typedef struct packed {
    logic        ag; logic bg;
    logic        av; logic [31:0] ard;
    logic        bv; logic [31:0] brd;
    logic [31:0] ma; logic [31:0] mdw; logic [2:0] mc;
    logic        mr; logic mw; logic bz;
  } out_t;

  typedef struct {
    string name;
    in_t   stim;
    out_t  exp;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_mis = 0;
  out_t act;

  assign act = {a_gnt, b_gnt, a_rvalid, a_rdata, b_rvalid, b_rdata,
                m_addr, m_dataW, m_ctrl, m_memR, m_memW, busy};

  function automatic in_t mi(logic ar, logic aw, logic [31:0] aa, logic [31:0] ad,
                             logic [2:0] ac, logic br, logic bw, logic [31:0] ba,
                             logic [31:0] bd, logic [2:0] bc, logic [31:0] dr);
    mi = '{ar, aw, aa, ad, ac, br, bw, ba, bd, bc, dr};
  endfunction

  function automatic out_t mo(logic ag, logic bg, logic av, logic [31:0] ard,
                              logic bv, logic [31:0] brd, logic [31:0] ma,
                              logic [31:0] mdw, logic [2:0] mc, logic mr,
                              logic mw, logic bz);
    mo = '{ag, bg, av, ard, bv, brd, ma, mdw, mc, mr, mw, bz};
  endfunction

  task automatic drive(input in_t v);
    a_req = v.ar; a_we = v.aw; a_addr = v.aa; a_wdata = v.ad; a_ctrl = v.ac;
    b_req = v.br; b_we = v.bw; b_addr = v.ba; b_wdata = v.bd; b_ctrl = v.bc;
    m_dataR = v.dr;
  endtask

  task automatic chk(input string nm, input out_t exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    // A read 0x10 ctrl 010
    tbl.push_back('{"a_rd_gnt",  mi(1,0,32'h10,0,3'b010, 0,0,0,0,0, 0),
                                 mo(1,0,0,0,0,0, 0,0,0,0,0,0)});
    tbl.push_back('{"a_rd_acc",  mi(0,0,0,0,0, 0,0,0,0,0, 32'hDEADBEEF),
                                 mo(0,0,0,0,0,0, 32'h10,0,3'b010,1,0,1)});
    tbl.push_back('{"a_rd_resp", mi(0,0,0,0,0, 0,0,0,0,0, 0),
                                 mo(0,0,1,32'hDEADBEEF,0,0, 0,0,0,0,0,1)});
    tbl.push_back('{"a_rd_idle", mi(0,0,0,0,0, 0,0,0,0,0, 0),
                                 mo(0,0,0,0,0,0, 0,0,0,0,0,0)});
    // B write 0x20
    tbl.push_back('{"b_wr_gnt",  mi(0,0,0,0,0, 1,1,32'h20,32'h12345678,3'b001, 0),
                                 mo(0,1,0,0,0,0, 0,0,0,0,0,0)});
    tbl.push_back('{"b_wr_acc",  mi(0,0,0,0,0, 0,0,0,0,0, 32'hAAAA5555),
                                 mo(0,0,0,0,0,0, 32'h20,32'h12345678,3'b001,0,1,1)});
    tbl.push_back('{"b_wr_resp", mi(0,0,0,0,0, 0,0,0,0,0, 32'hAAAA5555),
                                 mo(0,0,0,0,1,0, 0,0,0,0,0,1)});
    tbl.push_back('{"b_wr_idle", mi(0,0,0,0,0, 0,0,0,0,0, 0),
                                 mo(0,0,0,0,0,0, 0,0,0,0,0,0)});
    // Both requesting for 12 cycles; last grant was B so A goes first
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        tbl.push_back('{"rr_a_gnt",  mi(1,0,32'h100,0,3'd2, 1,1,32'h200,32'hCAFE,3'd1, 32'h11111111),
                                     mo(1,0,0,0,0,0, 0,0,0,0,0,0)});
        tbl.push_back('{"rr_a_acc",  mi(1,0,32'h100,0,3'd2, 1,1,32'h200,32'hCAFE,3'd1, 32'h11111111),
                                     mo(0,0,0,0,0,0, 32'h100,0,3'd2,1,0,1)});
        tbl.push_back('{"rr_a_resp", mi(1,0,32'h100,0,3'd2, 1,1,32'h200,32'hCAFE,3'd1, 32'h11111111),
                                     mo(0,0,1,32'h11111111,0,0, 0,0,0,0,0,1)});
      end else begin
        tbl.push_back('{"rr_b_gnt",  mi(1,0,32'h100,0,3'd2, 1,1,32'h200,32'hCAFE,3'd1, 32'h11111111),
                                     mo(0,1,0,0,0,0, 0,0,0,0,0,0)});
        tbl.push_back('{"rr_b_acc",  mi(1,0,32'h100,0,3'd2, 1,1,32'h200,32'hCAFE,3'd1, 32'h11111111),
                                     mo(0,0,0,0,0,0, 32'h200,32'hCAFE,3'd1,0,1,1)});
        tbl.push_back('{"rr_b_resp", mi(1,0,32'h100,0,3'd2, 1,1,32'h200,32'hCAFE,3'd1, 32'h11111111),
                                     mo(0,0,0,0,1,0, 0,0,0,0,0,1)});
      end
    end
    tbl.push_back('{"rr_idle",   mi(0,0,0,0,0, 0,0,0,0,0, 0),
                                 mo(0,0,0,0,0,0, 0,0,0,0,0,0)});
    // A pulses req for one cycle while B is in ACCESS
    tbl.push_back('{"pulse_bgnt", mi(0,0,0,0,0, 1,1,32'h30,32'h77,3'd0, 0),
                                  mo(0,1,0,0,0,0, 0,0,0,0,0,0)});
    tbl.push_back('{"pulse_acc",  mi(1,0,32'h40,0,3'd2, 0,0,0,0,0, 0),
                                  mo(0,0,0,0,0,0, 32'h30,32'h77,3'd0,0,1,1)});
    tbl.push_back('{"pulse_resp", mi(0,0,0,0,0, 0,0,0,0,0, 0),
                                  mo(0,0,0,0,1,0, 0,0,0,0,0,1)});
    tbl.push_back('{"pulse_idl1", mi(0,0,0,0,0, 0,0,0,0,0, 0),
                                  mo(0,0,0,0,0,0, 0,0,0,0,0,0)});
    tbl.push_back('{"pulse_idl2", mi(0,0,0,0,0, 0,0,0,0,0, 0),
                                  mo(0,0,0,0,0,0, 0,0,0,0,0,0)});
    // Read with ctrl 100: m_ctrl only visible during ACCESS
    tbl.push_back('{"c4_gnt",  mi(1,0,32'h44,0,3'b100, 0,0,0,0,0, 0),
                               mo(1,0,0,0,0,0, 0,0,0,0,0,0)});
    tbl.push_back('{"c4_acc",  mi(0,0,0,0,0, 0,0,0,0,0, 32'h0BAD0000),
                               mo(0,0,0,0,0,0, 32'h44,0,3'b100,1,0,1)});
    tbl.push_back('{"c4_resp", mi(0,0,0,0,0, 0,0,0,0,0, 0),
                               mo(0,0,1,32'h0BAD0000,0,0, 0,0,0,0,0,1)});
    tbl.push_back('{"c4_idle", mi(0,0,0,0,0, 0,0,0,0,0, 0),
                               mo(0,0,0,0,0,0, 0,0,0,0,0,0)});

    // Reset with both requests high: nothing may be granted
    rst_n = 1'b0;
    drive(mi(1,0,32'h10,0,3'd2, 1,1,32'h20,32'h1,3'd1, 0));
    #2;
    chk("reset_state", mo(0,0,0,0,0,0, 0,0,0,0,0,0));
    @(negedge clk);
    @(negedge clk);
    drive(mi(0,0,0,0,0, 0,0,0,0,0, 0));
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].stim);
      #2;
      chk(tbl[i].name, tbl[i].exp);
    end

    // Reset asserted in the middle of a B write ACCESS cycle
    @(negedge clk);
    drive(mi(0,0,0,0,0, 1,1,32'h20,32'h12345678,3'b001, 0));
    #2;
    chk("rst_b_gnt", mo(0,1,0,0,0,0, 0,0,0,0,0,0));
    @(negedge clk);
    drive(mi(0,0,0,0,0, 0,0,0,0,0, 0));
    #2;
    chk("rst_b_acc", mo(0,0,0,0,0,0, 32'h20,32'h12345678,3'b001,0,1,1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_immediate", mo(0,0,0,0,0,0, 0,0,0,0,0,0));
    @(negedge clk);
    #2;
    chk("rst_no_rvalid", mo(0,0,0,0,0,0, 0,0,0,0,0,0));
    @(negedge clk);
    rst_n = 1'b1;
    drive(mi(1,0,32'h50,0,3'd2, 1,0,32'h60,0,3'd2, 32'h5A5A5A5A));
    #2;
    chk("post_rst_a_first", mo(1,0,0,0,0,0, 0,0,0,0,0,0));
    @(negedge clk);
    drive(mi(0,0,0,0,0, 0,0,0,0,0, 32'h5A5A5A5A));
    #2;
    chk("post_rst_acc", mo(0,0,0,0,0,0, 32'h50,0,3'd2,1,0,1));
    @(negedge clk);
    #2;
    chk("post_rst_resp", mo(0,0,1,32'h5A5A5A5A,0,0, 0,0,0,0,0,1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have the following ports, one per line as name, direction, width, meaning.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- a_req  in  1  requester A (load/store unit) access request.
- a_we  in  1  A: 1 = write, 0 = read.
- a_addr  in  32  A byte address.
- a_wdata  in  32  A write data.
- a_ctrl  in  3  A memory-controller access code (size/sign).
- a_gnt  out  1  A request accepted this cycle.
- a_rvalid  out  1  A access complete; a_rdata valid.
- a_rdata  out  32  A read data.
- b_req, b_we, b_addr, b_wdata, b_ctrl, b_gnt, b_rvalid, b_rdata: same directions, widths and meanings for requester B (debug/DMA port).
- m_addr  out  32  address to memory path.
- m_dataW  out  32  write data to memory path.
- m_ctrl  out  3  access code to memory path.
- m_memR  out  1  memory read strobe.
- m_memW  out  1  memory write strobe.
- m_dataR  in  32  read data from memory path, valid in the same cycle as m_memR.
- busy  out  1  high when state is not IDLE.

Function
REQ-002 The FSM SHALL have three states: IDLE, ACCESS and RESP. Transitions: IDLE->ACCESS on grant; ACCESS->RESP always; RESP->IDLE always.
REQ-003 In IDLE with exactly one req high, that requester SHALL be granted.
REQ-004 In IDLE with both reqs high, the requester other than last_gnt SHALL be granted. last_gnt resets to B, so A wins the first contention.
REQ-005 x_gnt SHALL be combinational, high only in IDLE for the chosen requester, and at most one gnt SHALL be high per cycle.
REQ-006 On grant, the block SHALL capture we, addr, wdata and ctrl of the winner plus the winner id into internal registers, and SHALL update last_gnt.
REQ-007 Requesters SHALL hold req and fields stable until gnt. A req dropped before gnt SHALL have no effect. req still high after gnt SHALL be treated as a new request at the next IDLE.
REQ-008 In ACCESS, m_addr, m_dataW and m_ctrl SHALL equal the captured values, m_ctrl passed unchanged. Exactly one of m_memR (read) or m_memW (write) SHALL be high, for exactly one cycle.
REQ-009 Outside ACCESS, m_memR and m_memW SHALL be 0 and m_addr, m_dataW and m_ctrl SHALL be 0.
REQ-010 For reads, m_dataR SHALL be registered at the end of ACCESS into the response register.
REQ-011 In RESP, the winner's x_rvalid SHALL be high for exactly one cycle. x_rdata SHALL equal the registered read data for reads and 0 for writes. The non-winner's rvalid SHALL be 0.
REQ-012 x_rdata SHALL be 0 whenever x_rvalid is 0.
REQ-013 Requests arriving in ACCESS or RESP SHALL NOT be granted until IDLE. Service interval is 3 cycles per access.
REQ-014 With both reqs held continuously, grants SHALL alternate A,B,A,B with no starvation.

Reset
REQ-015 rst_n low SHALL immediately, without waiting for clk, force: state IDLE; last_gnt = B; all captured and response registers 0; all outputs 0.
REQ-016 Reset mid-ACCESS SHALL deassert m_memW and m_memR immediately and drop the transaction: no rvalid SHALL follow.
REQ-017 After rst_n rises, the first grant SHALL occur no earlier than the first rising edge with rst_n high.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- A read, a_addr=0x10, a_ctrl=3'b010, m_dataR=0xDEADBEEF -> a_gnt cycle 0; m_memR=1 and m_addr=0x10 in cycle 1; a_rvalid=1 and a_rdata=0xDEADBEEF in cycle 2; busy low in cycle 3.
- B write, b_addr=0x20, b_wdata=0x12345678, b_ctrl=3'b001 -> single-cycle m_memW with m_dataW=0x12345678 and m_ctrl=3'b001; b_rvalid=1 with b_rdata=0; m_memR never high.
- A and B both requesting continuously for 12 cycles -> grants in the order A,B,A,B, spaced 3 cycles apart; never both gnt in the same cycle.
- rst_n pulled low in the middle of the ACCESS cycle of a B write -> m_memW drops the same cycle; no b_rvalid; after release, simultaneous requests are granted to A first.
- A raises a_req for 1 cycle while B's access is in ACCESS, then drops it -> a_gnt never asserts; no memory strobe for A.
- Read with a_ctrl=3'b100 -> m_ctrl=3'b100 during ACCESS and 0 in IDLE and RESP.
